// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

   localparam int unsigned KEY_W    = 4;
   localparam int unsigned NUM_COLS = 4;

   typedef enum logic [1:0] {
      IDLE,
      CONFIRM,
      HELD,
      RELEASE
   } state_t;

   typedef enum logic [1:0] {
      NONE,
      KEY,
      MULTI
   } summary_t;

   function automatic logic [KEY_W-1:0] key_code(input logic [1:0] row, input logic [1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// Column strobe, row synchronizer and per-frame accumulator for a 4x4 keypad.
module keypad_col_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_CLK_N = 15
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [3:0]       i_row_n,
   output logic [3:0]       o_col_n,
   output logic             o_frame_done,
   output summary_t         o_summary,
   output logic [KEY_W-1:0] o_frame_key
);

   logic [3:0]            row_s1;
   logic [3:0]            row_s2;
   logic [SCAN_CLK_N-1:0] div;
   logic [1:0]            col;
   logic                  tick;
   logic [1:0]            acc_cnt;
   logic [KEY_W-1:0]      acc_code;
   logic [1:0]            hits;
   logic [KEY_W-1:0]      code;

   assign tick    = &div;
   assign o_col_n = ~(4'b0001 << col);

   // Fold the current column's rows into the running frame totals; count saturates at 2.
   always_comb begin
      hits = acc_cnt;
      code = acc_code;
      for (int unsigned r = 0; r < 4; r++) begin
         if (!row_s2[r]) begin
            if (hits != 2'd2) begin
               hits = hits + 2'd1;
            end
            code = key_code(2'(r), col);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         row_s1       <= '1;
         row_s2       <= '1;
         div          <= '0;
         col          <= '0;
         acc_cnt      <= '0;
         acc_code     <= '0;
         o_frame_done <= 1'b0;
         o_summary    <= NONE;
         o_frame_key  <= '0;
      end else begin
         row_s1       <= i_row_n;
         row_s2       <= row_s1;
         div          <= div + 1'b1;
         o_frame_done <= 1'b0;
         if (tick) begin
            col <= col + 2'd1;
            if (col == 2'd3) begin
               o_frame_done <= 1'b1;
               o_frame_key  <= code;
               case (hits)
                  2'd0:    o_summary <= NONE;
                  2'd1:    o_summary <= KEY;
                  default: o_summary <= MULTI;
               endcase
               acc_cnt  <= '0;
               acc_code <= '0;
            end else begin
               acc_cnt  <= hits;
               acc_code <= code;
            end
         end
      end
   end

endmodule

// File: rtl/keypad_4x4_scan.sv
// 4x4 keypad scanner: frame-based debounce FSM with a one-entry valid/ready output buffer.
module keypad_4x4_scan
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_CLK_N     = 15,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [3:0] i_row_n,
   output logic [3:0] o_col_n,
   output logic [3:0] o_key,
   output logic       o_key_valid,
   input  logic       i_key_ready,
   output logic       o_pressed,
   output logic       o_overrun
);

   localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

   logic             frame_done;
   summary_t         summary;
   logic [KEY_W-1:0] frame_key;

   state_t           state;
   state_t           state_nx;
   logic [3:0]       cnt;
   logic [3:0]       cnt_nx;
   logic [KEY_W-1:0] cand;
   logic [KEY_W-1:0] cand_nx;
   logic             emit;
   logic             handshake;

   keypad_col_scanner #(
      .SCAN_CLK_N (SCAN_CLK_N)
   ) u_scanner (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_row_n      (i_row_n),
      .o_col_n      (o_col_n),
      .o_frame_done (frame_done),
      .o_summary    (summary),
      .o_frame_key  (frame_key)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= IDLE;
         cnt   <= '0;
         cand  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         cand  <= cand_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cand_nx  = cand;
      emit     = 1'b0;
      if (frame_done) begin
         unique case (state)
            IDLE: begin
               if (summary == KEY) begin
                  cand_nx = frame_key;
                  if (DEB <= 4'd1) begin
                     emit     = 1'b1;
                     state_nx = HELD;
                  end else begin
                     cnt_nx   = 4'd1;
                     state_nx = CONFIRM;
                  end
               end
            end
            CONFIRM: begin
               if (summary == KEY) begin
                  if (frame_key == cand) begin
                     cnt_nx = cnt + 4'd1;
                     if (cnt + 4'd1 >= DEB) begin
                        emit     = 1'b1;
                        state_nx = HELD;
                     end
                  end else begin
                     cand_nx = frame_key;
                     cnt_nx  = 4'd1;
                  end
               end else begin
                  cnt_nx   = '0;
                  state_nx = IDLE;
               end
            end
            HELD: begin
               if (summary == NONE) begin
                  cnt_nx   = 4'd1;
                  state_nx = RELEASE;
               end
            end
            RELEASE: begin
               if (summary == NONE) begin
                  cnt_nx = cnt + 4'd1;
                  if (cnt + 4'd1 >= DEB) begin
                     cnt_nx   = '0;
                     state_nx = IDLE;
                  end
               end else begin
                  state_nx = HELD;
               end
            end
            default: begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end
         endcase
      end
   end

   assign handshake = o_key_valid & i_key_ready;

   // A same-cycle handshake frees the slot, so an emit then replaces the code instead of overrunning.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_key       <= '0;
         o_key_valid <= 1'b0;
         o_overrun   <= 1'b0;
      end else if (emit) begin
         if (!o_key_valid || i_key_ready) begin
            o_key       <= cand_nx;
            o_key_valid <= 1'b1;
         end else begin
            o_overrun   <= 1'b1;
         end
      end else if (handshake) begin
         o_key_valid <= 1'b0;
      end
   end

   assign o_pressed = (state == HELD) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_4x4_scan.sv
// Directed bench for keypad_4x4_scan with a matrix model driven from the column strobe.
module tb_keypad_4x4_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key;
   logic        valid;
   logic        ready;
   logic        pressed;
   logic        overrun;
   logic [15:0] keys;
   int          cyc;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   always_comb begin
      row_n = '1;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
         end
      end
   end

   keypad_4x4_scan #(
      .SCAN_CLK_N     (2),
      .DEBOUNCE_SCANS (2)
   ) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_row_n     (row_n),
      .o_col_n     (col_n),
      .o_key       (key),
      .o_key_valid (valid),
      .i_key_ready (ready),
      .o_pressed   (pressed),
      .o_overrun   (overrun)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #60000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      ready = 1'b0;
      keys  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_col", 32'(col_n), 32'hE);
      check_eq("rst_key", 32'(key), 32'h0);
      check_eq("rst_valid", 32'(valid), 32'h0);
      check_eq("rst_pressed", 32'(pressed), 32'h0);
      check_eq("rst_overrun", 32'(overrun), 32'h0);
      rst = 1'b0;

      goto(3);  check_eq("col_pre_tick", 32'(col_n), 32'hE);
      goto(4);  check_eq("col_1", 32'(col_n), 32'hD);
      goto(8);  check_eq("col_2", 32'(col_n), 32'hB);
      goto(12); check_eq("col_3", 32'(col_n), 32'h7);
      goto(16); check_eq("col_wrap", 32'(col_n), 32'hE);

      // key 9 held for three frames
      keys = 16'(1) << 9;
      goto(48); check_eq("k9_valid_early", 32'(valid), 32'h0);
      goto(49);
      check_eq("k9_valid", 32'(valid), 32'h1);
      check_eq("k9_key", 32'(key), 32'h9);
      check_eq("k9_pressed", 32'(pressed), 32'h1);
      ready = 1'b1;
      goto(50); check_eq("k9_handshake", 32'(valid), 32'h0);
      ready = 1'b0;
      goto(64); keys = '0;
      goto(65);
      check_eq("k9_no_repeat", 32'(valid), 32'h0);
      check_eq("k9_still_held", 32'(pressed), 32'h1);
      goto(81); check_eq("k9_release_state", 32'(pressed), 32'h1);
      goto(97); check_eq("k9_released", 32'(pressed), 32'h0);

      // one-frame glitch on key 5
      keys = 16'(1) << 5;
      goto(112); keys = '0;
      goto(113);
      check_eq("glitch_pressed", 32'(pressed), 32'h0);
      check_eq("glitch_valid", 32'(valid), 32'h0);
      goto(129);
      check_eq("glitch_idle_pressed", 32'(pressed), 32'h0);
      check_eq("glitch_idle_valid", 32'(valid), 32'h0);

      // keys 0 and 15 together, then key 0 alone
      keys = 16'h8001;
      goto(192);
      check_eq("multi_valid", 32'(valid), 32'h0);
      check_eq("multi_pressed", 32'(pressed), 32'h0);
      keys = 16'h0001;
      goto(224); check_eq("k0_valid_early", 32'(valid), 32'h0);
      goto(225);
      check_eq("k0_valid", 32'(valid), 32'h1);
      check_eq("k0_key", 32'(key), 32'h0);
      ready = 1'b1;
      goto(226); check_eq("k0_handshake", 32'(valid), 32'h0);
      ready = 1'b0;
      goto(240); keys = '0;
      goto(273); check_eq("k0_released", 32'(pressed), 32'h0);

      // overrun: key 3 left unread, then key 7
      keys = 16'(1) << 3;
      goto(304); keys = '0;
      goto(305);
      check_eq("k3_valid", 32'(valid), 32'h1);
      check_eq("k3_key", 32'(key), 32'h3);
      goto(337);
      check_eq("k3_released", 32'(pressed), 32'h0);
      keys = 16'(1) << 7;
      goto(368);
      check_eq("ovr_before", 32'(overrun), 32'h0);
      goto(369);
      check_eq("ovr_set", 32'(overrun), 32'h1);
      check_eq("ovr_key_kept", 32'(key), 32'h3);
      check_eq("ovr_valid", 32'(valid), 32'h1);
      ready = 1'b1;
      goto(370);
      check_eq("ovr_handshake", 32'(valid), 32'h0);
      check_eq("ovr_sticky", 32'(overrun), 32'h1);
      ready = 1'b0;
      keys  = '0;
      goto(401);
      check_eq("ovr_sticky_late", 32'(overrun), 32'h1);
      check_eq("k7_released", 32'(pressed), 32'h0);

      // reset while confirming key 9
      keys = 16'(1) << 9;
      goto(417);
      check_eq("confirm_valid", 32'(valid), 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("mid_rst_col", 32'(col_n), 32'hE);
      check_eq("mid_rst_overrun", 32'(overrun), 32'h0);
      check_eq("mid_rst_valid", 32'(valid), 32'h0);
      check_eq("mid_rst_pressed", 32'(pressed), 32'h0);
      check_eq("mid_rst_key", 32'(key), 32'h0);
      @(posedge clk);
      #1;
      keys = '0;
      rst  = 1'b0;
      goto(16);
      check_eq("post_rst_valid", 32'(valid), 32'h0);
      keys = 16'(1) << 9;
      goto(48); check_eq("post_rst_valid_early", 32'(valid), 32'h0);
      goto(49);
      check_eq("post_rst_valid_set", 32'(valid), 32'h1);
      check_eq("post_rst_key", 32'(key), 32'h9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
